alu_control_seq: RTL and testbench
==================================

Name: alu_control_seq

Overview:
Parametrised successor to the single-cycle ALU control decoder. Decodes {ALUOp, funct} into an ALU operation code and registers it, with one cycle of latency. Adds multi-cycle multiply sequencing: it issues a start pulse, counts a fixed number of cycles, stalls upstream through a valid/ready handshake, and pulses the HI/LO write enable when done. It sits between the main control unit and the ALU / mult unit in the MIPS datapath.

Parameters:
OP_WIDTH, 3, ALUOp width
FUNCT_WIDTH, 6, function-field width
OPER_WIDTH, 4, ALU operation code width
MULDIV_CYCLES, 32, busy cycles for MULT/MULTU (must be >= 2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
valid_in  input  1  {alu_op, funct} valid this cycle
ready_out  output  1  block can accept a request
alu_op  input  OP_WIDTH  ALUOp from the control unit
funct  input  FUNCT_WIDTH  instruction function field
alu_operation  output  OPER_WIDTH  registered operation code to the ALU
op_valid  output  1  alu_operation valid (one-cycle pulse per accepted request)
muldiv_start  output  1  one-cycle start pulse to the mult unit
stall  output  1  multi-cycle operation in progress
hilo_we  output  1  one-cycle HI/LO write enable at completion
illegal  output  1  one-cycle pulse on an undecodable request (see Optional Feature)

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high. On reset: state=IDLE, counter=0, alu_operation=4'b1001, and op_valid, muldiv_start, stall, hilo_we, illegal all 0. ready_out=1 from the first cycle after reset deasserts.
- Accept: a request is taken when valid_in && ready_out at a rising edge. ready_out = (state==IDLE) || (state==ISSUE && the issued op was single-cycle).
- Decode, with the result registered:
  - alu_op 111 (R-type), by funct: 100100 AND->0000; 100101 OR->0001; 100111 NOR->0010; 100000 ADD->0011; 100010 SUB->0100; 000000 SLL->0110; 000010 SRL->0111; 101010 SLT->1000; 011000 MULT->1010; 011001 MULTU->1011.
  - By alu_op alone, funct ignored: 000 ANDI->0000; 001 ORI->0001; 100 ADDI->0011; 101 LUI->0101; 110 BEQ/BNE->0100.
  - Anything else: 1001, marked illegal.
- States: IDLE, ISSUE, BUSY.
  - IDLE: on accept -> ISSUE. alu_operation is loaded from the decode.
  - ISSUE, single-cycle op: op_valid=1. If another accept happens this cycle, stay in ISSUE with the new code (back-to-back at full throughput); otherwise -> IDLE.
  - ISSUE, MULT/MULTU: muldiv_start=1, stall=1, ready_out=0, counter loaded with MULDIV_CYCLES-1; -> BUSY.
  - BUSY: stall=1, ready_out=0, counter decrements each cycle, valid_in ignored. When counter==0: hilo_we=1 and op_valid=1 for that cycle, -> IDLE. stall drops the cycle after hilo_we.
  - Total stall duration = MULDIV_CYCLES+1 cycles (ISSUE plus BUSY).
- alu_operation holds its last value while idle or busy. It changes only on accept.
- Counter width is $clog2(MULDIV_CYCLES). It never wraps: it is reloaded only in ISSUE.
- Reset mid-operation (any state) immediately forces the reset values. No hilo_we is produced for the aborted operation.
- valid_in while ready_out=0: the request is not taken. Upstream must hold it until accepted.

Optional Feature:
- Macro ALU_ILLEGAL_TRAP_EN.
- Defined: an undecodable accept sets alu_operation=1001, pulses illegal=1 in the ISSUE cycle, and leaves op_valid at 0.
- Undefined: illegal is tied to 0; an undecodable accept behaves as a normal single-cycle op (alu_operation=1001, op_valid=1).

Test Plan:
- Reset released, alu_op=111, funct=100000, valid_in=1 -> next cycle alu_operation=0011, op_valid=1, ready_out=1.
- Back-to-back ANDI (000), LUI (101), BEQ (110) on consecutive cycles -> alu_operation 0000, 0101, 0100 on consecutive cycles, op_valid held 1.
- MULT (111/011000), MULDIV_CYCLES=4 -> muldiv_start pulse, stall high 5 cycles, ready_out=0 throughout, hilo_we and op_valid together in the last stall cycle with alu_operation=1010; an ADD presented during the stall is accepted only after stall drops.
- reset asserted in the 2nd BUSY cycle of MULTU -> all outputs return to reset values asynchronously; no hilo_we pulse follows.
- alu_op=111, funct=111111: with ALU_ILLEGAL_TRAP_EN -> illegal=1, op_valid=0, alu_operation=1001; without it -> illegal=0, op_valid=1, alu_operation=1001.
- alu_op=011 (unused) -> treated as illegal, same responses as the previous case.

Source files
------------

// File: rtl/alu_control_seq.sv
// ALU control decoder with registered output and multi-cycle MULT/MULTU sequencing.
// Optional macro ALU_ILLEGAL_TRAP_EN: undecodable requests pulse illegal instead of op_valid.
module alu_control_seq #(
    parameter int OP_WIDTH      = 3,
    parameter int FUNCT_WIDTH   = 6,
    parameter int OPER_WIDTH    = 4,
    parameter int MULDIV_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [OP_WIDTH-1:0]    alu_op,
    input  logic [FUNCT_WIDTH-1:0] funct,
    output logic [OPER_WIDTH-1:0]  alu_operation,
    output logic                   op_valid,
    output logic                   muldiv_start,
    output logic                   stall,
    output logic                   hilo_we,
    output logic                   illegal
);

    localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    localparam logic [OP_WIDTH-1:0] OP_ANDI  = OP_WIDTH'(3'b000);
    localparam logic [OP_WIDTH-1:0] OP_ORI   = OP_WIDTH'(3'b001);
    localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(3'b100);
    localparam logic [OP_WIDTH-1:0] OP_LUI   = OP_WIDTH'(3'b101);
    localparam logic [OP_WIDTH-1:0] OP_BR    = OP_WIDTH'(3'b110);
    localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(3'b111);

    localparam logic [FUNCT_WIDTH-1:0] F_AND   = FUNCT_WIDTH'(6'b100100);
    localparam logic [FUNCT_WIDTH-1:0] F_OR    = FUNCT_WIDTH'(6'b100101);
    localparam logic [FUNCT_WIDTH-1:0] F_NOR   = FUNCT_WIDTH'(6'b100111);
    localparam logic [FUNCT_WIDTH-1:0] F_ADD   = FUNCT_WIDTH'(6'b100000);
    localparam logic [FUNCT_WIDTH-1:0] F_SUB   = FUNCT_WIDTH'(6'b100010);
    localparam logic [FUNCT_WIDTH-1:0] F_SLL   = FUNCT_WIDTH'(6'b000000);
    localparam logic [FUNCT_WIDTH-1:0] F_SRL   = FUNCT_WIDTH'(6'b000010);
    localparam logic [FUNCT_WIDTH-1:0] F_SLT   = FUNCT_WIDTH'(6'b101010);
    localparam logic [FUNCT_WIDTH-1:0] F_MULT  = FUNCT_WIDTH'(6'b011000);
    localparam logic [FUNCT_WIDTH-1:0] F_MULTU = FUNCT_WIDTH'(6'b011001);

    localparam logic [OPER_WIDTH-1:0] OPER_ILLEGAL = OPER_WIDTH'(4'b1001);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [OPER_WIDTH-1:0]  oper_q, oper_d;
    logic                   mul_q, mul_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OPER_WIDTH-1:0]  dec_op;
    logic                   dec_mul;
    logic                   accept;

    always_comb begin
        dec_op  = OPER_ILLEGAL;
        dec_mul = 1'b0;
        case (alu_op)
            OP_ANDI: dec_op = OPER_WIDTH'(4'b0000);
            OP_ORI:  dec_op = OPER_WIDTH'(4'b0001);
            OP_ADDI: dec_op = OPER_WIDTH'(4'b0011);
            OP_LUI:  dec_op = OPER_WIDTH'(4'b0101);
            OP_BR:   dec_op = OPER_WIDTH'(4'b0100);
            OP_RTYPE: begin
                case (funct)
                    F_AND:   dec_op = OPER_WIDTH'(4'b0000);
                    F_OR:    dec_op = OPER_WIDTH'(4'b0001);
                    F_NOR:   dec_op = OPER_WIDTH'(4'b0010);
                    F_ADD:   dec_op = OPER_WIDTH'(4'b0011);
                    F_SUB:   dec_op = OPER_WIDTH'(4'b0100);
                    F_SLL:   dec_op = OPER_WIDTH'(4'b0110);
                    F_SRL:   dec_op = OPER_WIDTH'(4'b0111);
                    F_SLT:   dec_op = OPER_WIDTH'(4'b1000);
                    F_MULT:  begin dec_op = OPER_WIDTH'(4'b1010); dec_mul = 1'b1; end
                    F_MULTU: begin dec_op = OPER_WIDTH'(4'b1011); dec_mul = 1'b1; end
                    default: dec_op = OPER_ILLEGAL;
                endcase
            end
            default: dec_op = OPER_ILLEGAL;
        endcase
    end

`ifdef ALU_ILLEGAL_TRAP_EN
    // 1001 is produced only by undecodable requests, so it doubles as the illegal flag.
    logic dec_bad;
    logic ill_q, ill_d;
    assign dec_bad = (dec_op == OPER_ILLEGAL);
`endif

    assign accept = valid_in && ready_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            oper_q  <= OPER_ILLEGAL;
            mul_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef ALU_ILLEGAL_TRAP_EN
            ill_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            oper_q  <= oper_d;
            mul_q   <= mul_d;
            cnt_q   <= cnt_d;
`ifdef ALU_ILLEGAL_TRAP_EN
            ill_q   <= ill_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        oper_d  = oper_q;
        mul_d   = mul_q;
        cnt_d   = cnt_q;
`ifdef ALU_ILLEGAL_TRAP_EN
        ill_d   = ill_q;
`endif
        case (state_q)
            IDLE, ISSUE: begin
                if (state_q == ISSUE && mul_q) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                end else if (accept) begin
                    state_d = ISSUE;
                    oper_d  = dec_op;
                    mul_d   = dec_mul;
`ifdef ALU_ILLEGAL_TRAP_EN
                    ill_d   = dec_bad;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_out    = (state_q == IDLE) || (state_q == ISSUE && !mul_q);
        muldiv_start = (state_q == ISSUE) && mul_q;
        stall        = ((state_q == ISSUE) && mul_q) || (state_q == BUSY);
        hilo_we      = (state_q == BUSY) && (cnt_q == '0);
`ifdef ALU_ILLEGAL_TRAP_EN
        op_valid     = ((state_q == ISSUE) && !mul_q && !ill_q) || hilo_we;
        illegal      = (state_q == ISSUE) && ill_q;
`else
        op_valid     = ((state_q == ISSUE) && !mul_q) || hilo_we;
        illegal      = 1'b0;
`endif
    end

    assign alu_operation = oper_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq (MULDIV_CYCLES=4); expectations follow ALU_ILLEGAL_TRAP_EN.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic [2:0] alu_op = 3'b000;
    logic [5:0] funct = 6'b000000;
    logic [3:0] alu_operation;
    logic       op_valid, muldiv_start, stall, hilo_we, illegal;

    typedef struct packed {
        logic [3:0] op;
        logic       ov;
        logic       ill;
        logic       start;
        logic       hilo;
        logic       stl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   run_len = 0;
    int   max_run = 0;

    localparam int K_SINGLE = 0, K_MUL = 1, K_ILL = 2, K_MUL_ABORT = 3;

    alu_control_seq #(
        .OP_WIDTH(3), .FUNCT_WIDTH(6), .OPER_WIDTH(4), .MULDIV_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
        .alu_op(alu_op), .funct(funct), .alu_operation(alu_operation),
        .op_valid(op_valid), .muldiv_start(muldiv_start), .stall(stall),
        .hilo_we(hilo_we), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [3:0] op, logic ov, logic ill, logic st, logic hi, logic sl);
        exp_t e;
        e.op = op; e.ov = ov; e.ill = ill; e.start = st; e.hilo = hi; e.stl = sl;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("check %s ok: %0h", name, act);
        end
    endtask

    // Hold the request until it is taken, then queue the expected responses.
    task automatic send(input logic [2:0] op, input logic [5:0] f, input logic [3:0] code, input int kind);
        int   n;
        logic r;
        alu_op = op; funct = f; valid_in = 1'b1; n = 0;
        do begin
            @(negedge clk); r = ready_out;
            @(posedge clk); #1; n++;
        end while (!r && n < 50);
        valid_in = 1'b0;
        if (!r) begin
            checks++; errors++;
            $display("FAIL accept_timeout: op=%b funct=%b never accepted, required accept", op, f);
        end else begin
            $display("issue op=%b funct=%b expect code=%b kind=%0d", op, f, code, kind);
            case (kind)
                K_SINGLE: exp_q.push_back(mk(code, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
                K_MUL: begin
                    exp_q.push_back(mk(code, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
                    exp_q.push_back(mk(code, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
                end
`ifdef ALU_ILLEGAL_TRAP_EN
                K_ILL: exp_q.push_back(mk(4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
`else
                K_ILL: exp_q.push_back(mk(4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
`endif
                default: exp_q.push_back(mk(code, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
            endcase
        end
    endtask

    // Monitor: every output event pops one expected entry.
    always @(negedge clk) begin
        exp_t e, a;
        if (!reset) begin
            if (op_valid) run_len++; else run_len = 0;
            if (run_len > max_run) max_run = run_len;
            if (op_valid || illegal || muldiv_start || hilo_we) begin
                a = mk(alu_operation, op_valid, illegal, muldiv_start, hilo_we, stall);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got op=%b ov=%b ill=%b start=%b hilo=%b stall=%b, required no event",
                             a.op, a.ov, a.ill, a.start, a.hilo, a.stl);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL event: got op=%b ov=%b ill=%b start=%b hilo=%b stall=%b, required op=%b ov=%b ill=%b start=%b hilo=%b stall=%b",
                                 a.op, a.ov, a.ill, a.start, a.hilo, a.stl, e.op, e.ov, e.ill, e.start, e.hilo, e.stl);
                    end else begin
                        $display("event op=%b ov=%b ill=%b start=%b hilo=%b stall=%b ok",
                                 a.op, a.ov, a.ill, a.start, a.hilo, a.stl);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] t_op[13];
        logic [5:0] t_f[13];
        logic [3:0] t_c[13];
        int cnt, bad_ready, hilo_at, hilo_cnt;

        t_op = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                 3'b000, 3'b001, 3'b100, 3'b101, 3'b110};
        t_f  = '{6'b100100, 6'b100101, 6'b100111, 6'b100000, 6'b100010, 6'b000000, 6'b000010, 6'b101010,
                 6'b101010, 6'b111111, 6'b011000, 6'b000000, 6'b100101};
        t_c  = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111, 4'b1000,
                 4'b0000, 4'b0001, 4'b0011, 4'b0101, 4'b0100};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_oper", 32'(alu_operation), 32'h9);
        chk("reset_flags", 32'({op_valid, muldiv_start, stall, hilo_we, illegal}), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(ready_out), 32'h1);

        // Single ADD, one-cycle latency
        @(posedge clk); #1;
        send(3'b111, 6'b100000, 4'b0011, K_SINGLE);
        @(negedge clk);
        chk("add_ready", 32'(ready_out), 32'h1);
        chk("add_op_valid", 32'(op_valid), 32'h1);
        repeat (2) @(negedge clk);

        // Back-to-back ANDI, LUI, BEQ
        max_run = 0;
        @(posedge clk); #1;
        send(3'b000, 6'b011000, 4'b0000, K_SINGLE);
        send(3'b101, 6'b000000, 4'b0101, K_SINGLE);
        send(3'b110, 6'b111111, 4'b0100, K_SINGLE);
        repeat (2) @(negedge clk);
        chk("b2b_op_valid_run", 32'(max_run), 32'd3);

        // Full decode table back to back
        @(posedge clk); #1;
        for (int i = 0; i < 13; i++) send(t_op[i], t_f[i], t_c[i], K_SINGLE);
        repeat (2) @(negedge clk);
        chk("table_hold_oper", 32'(alu_operation), 32'h4);

        // MULT with an ADD waiting during the stall
        @(posedge clk); #1;
        send(3'b111, 6'b011000, 4'b1010, K_MUL);
        alu_op = 3'b111; funct = 6'b100000; valid_in = 1'b1;
        cnt = 0; bad_ready = 0; hilo_at = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall) break;
            cnt++;
            if (ready_out) bad_ready++;
            if (hilo_we) hilo_at = cnt;
        end
        chk("mult_stall_cycles", 32'(cnt), 32'd5);
        chk("mult_ready_low", 32'(bad_ready), 32'd0);
        chk("mult_hilo_cycle", 32'(hilo_at), 32'd5);
        chk("mult_ready_after", 32'(ready_out), 32'h1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        exp_q.push_back(mk(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        $display("issue op=111 funct=100000 expect code=0011 after stall");
        repeat (2) @(negedge clk);

        // MULTU aborted by reset in second BUSY cycle
        @(posedge clk); #1;
        send(3'b111, 6'b011001, 4'b1011, K_MUL_ABORT);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_oper", 32'(alu_operation), 32'h9);
        chk("abort_flags", 32'({op_valid, muldiv_start, stall, hilo_we, illegal}), 32'h0);
        #3 reset = 1'b0;
        hilo_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (hilo_we) hilo_cnt++;
        end
        chk("abort_no_hilo", 32'(hilo_cnt), 32'd0);

        // Undecodable requests
        @(posedge clk); #1;
        send(3'b111, 6'b111111, 4'b1001, K_ILL);
        @(negedge clk);
        chk("illegal_oper", 32'(alu_operation), 32'h9);
        @(posedge clk); #1;
        send(3'b011, 6'b100000, 4'b1001, K_ILL);
        send(3'b010, 6'b100100, 4'b1001, K_ILL);
        send(3'b001, 6'b000000, 4'b0001, K_SINGLE);

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
